// File: rtl/enemy_fire_scheduler.sv
// Enemy fire scheduler: round-robin column choice, bottom-most shooter pick,
// and a cooldown that shrinks as enemies die.
module enemy_fire_scheduler #(
  parameter int unsigned COLS        = 8,
  parameter int unsigned ROWS        = 3,
  parameter int unsigned PERIOD_BASE = 10000000,
  parameter int unsigned PERIOD_STEP = 300000,
  parameter int unsigned PERIOD_MIN  = 2000000
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic [COLS*ROWS-1:0]   i_alive,
  input  logic                   i_bullet_busy,
  input  logic                   i_fire_ack,
  output logic                   o_fire_req,
  output logic [3:0]             o_fire_col,
  output logic [1:0]             o_fire_row,
  output logic                   o_no_target,
  output logic [7:0]             o_shots_fired
);

  localparam int unsigned N  = COLS * ROWS;
  localparam int unsigned CW = 4;
  localparam int unsigned RW = 2;
  localparam int unsigned SW = 5;
  localparam int unsigned TW = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SCAN  = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  state_t          r_state;
  logic [TW-1:0]   r_cooldown;
  logic [CW-1:0]   r_rr_ptr;
  logic [CW-1:0]   r_scan_ptr;
  logic [SW-1:0]   r_steps;
  logic            r_fire_req;
  logic [CW-1:0]   r_fire_col;
  logic [RW-1:0]   r_fire_row;
  logic            r_no_target;
  logic [7:0]      r_shots;

  state_t          w_state_nxt;
  logic [TW-1:0]   w_cooldown_nxt;
  logic [CW-1:0]   w_rr_nxt;
  logic [CW-1:0]   w_scan_nxt;
  logic [SW-1:0]   w_steps_nxt;
  logic            w_req_nxt;
  logic [CW-1:0]   w_col_nxt;
  logic [RW-1:0]   w_row_nxt;
  logic            w_nt_nxt;
  logic [7:0]      w_shots_nxt;

  logic [TW-1:0]   w_alive_cnt;
  logic [TW-1:0]   w_dead;
  logic [TW-1:0]   w_cut;
  logic [TW-1:0]   w_reload;
  logic            w_col_hit;
  logic [RW-1:0]   w_col_row;

  function automatic logic [CW-1:0] f_wrap_inc(input logic [CW-1:0] p);
    return (p == CW'(COLS - 1)) ? '0 : p + CW'(1);
  endfunction

  // Cooldown reload: shorter with more dead enemies, floored at PERIOD_MIN
  always_comb begin
    w_alive_cnt = '0;
    for (int i = 0; i < N; i++) begin
      w_alive_cnt = w_alive_cnt + TW'(i_alive[i]);
    end
    w_dead = TW'(N) - w_alive_cnt;
    w_cut  = w_dead * TW'(PERIOD_STEP);
    if (w_cut > TW'(PERIOD_BASE)) begin
      w_reload = TW'(PERIOD_MIN);
    end else if ((TW'(PERIOD_BASE) - w_cut) < TW'(PERIOD_MIN)) begin
      w_reload = TW'(PERIOD_MIN);
    end else begin
      w_reload = TW'(PERIOD_BASE) - w_cut;
    end
  end

  // Column under scan: any living enemy, and the highest (bottom-most) row
  always_comb begin
    w_col_hit = 1'b0;
    w_col_row = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ((CW'(c) == r_scan_ptr) && i_alive[r*COLS + c]) begin
          w_col_hit = 1'b1;
          w_col_row = RW'(r);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cooldown_nxt = r_cooldown;
    w_rr_nxt       = r_rr_ptr;
    w_scan_nxt     = r_scan_ptr;
    w_steps_nxt    = r_steps;
    w_req_nxt      = r_fire_req;
    w_col_nxt      = r_fire_col;
    w_row_nxt      = r_fire_row;
    w_nt_nxt       = 1'b0;
    w_shots_nxt    = r_shots;

    if (!i_enable) begin
      w_state_nxt = S_IDLE;
      w_req_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_req_nxt      = 1'b0;
          w_state_nxt    = S_WAIT;
          w_cooldown_nxt = w_reload;
        end
        S_WAIT: begin
          if (r_cooldown != '0) begin
            w_cooldown_nxt = r_cooldown - TW'(1);
          end else if (!i_bullet_busy) begin
            w_state_nxt = S_SCAN;
            w_scan_nxt  = r_rr_ptr;
            w_steps_nxt = '0;
          end
        end
        S_SCAN: begin
          if (w_col_hit) begin
            w_col_nxt   = r_scan_ptr;
            w_row_nxt   = w_col_row;
            w_req_nxt   = 1'b1;
            w_state_nxt = S_ISSUE;
          end else if (r_steps == SW'(COLS - 1)) begin
            w_nt_nxt       = 1'b1;
            w_state_nxt    = S_WAIT;
            w_cooldown_nxt = w_reload;
          end else begin
            w_scan_nxt  = f_wrap_inc(r_scan_ptr);
            w_steps_nxt = r_steps + SW'(1);
          end
        end
        S_ISSUE: begin
          // Target stays latched; re-validating alive is downstream's job
          if (i_fire_ack) begin
            w_req_nxt      = 1'b0;
            w_shots_nxt    = r_shots + 8'd1;
            w_rr_nxt       = f_wrap_inc(r_fire_col);
            w_state_nxt    = S_WAIT;
            w_cooldown_nxt = w_reload;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cooldown  <= '0;
      r_rr_ptr    <= '0;
      r_scan_ptr  <= '0;
      r_steps     <= '0;
      r_fire_req  <= 1'b0;
      r_fire_col  <= '0;
      r_fire_row  <= '0;
      r_no_target <= 1'b0;
      r_shots     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cooldown  <= w_cooldown_nxt;
      r_rr_ptr    <= w_rr_nxt;
      r_scan_ptr  <= w_scan_nxt;
      r_steps     <= w_steps_nxt;
      r_fire_req  <= w_req_nxt;
      r_fire_col  <= w_col_nxt;
      r_fire_row  <= w_row_nxt;
      r_no_target <= w_nt_nxt;
      r_shots     <= w_shots_nxt;
    end
  end

  assign o_fire_req    = r_fire_req;
  assign o_fire_col    = r_fire_col;
  assign o_fire_row    = r_fire_row;
  assign o_no_target   = r_no_target;
  assign o_shots_fired = r_shots;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Self-checking bench for enemy_fire_scheduler: directed scenarios plus
// randomized shots against a transaction-level reference model.
module tb_enemy_fire_scheduler;

  localparam int unsigned COLS = 8;
  localparam int unsigned ROWS = 3;
  localparam int unsigned BASE = 100;
  localparam int unsigned STEP = 2;
  localparam int unsigned PMIN = 20;
  localparam int unsigned N    = COLS * ROWS;

  logic         clk = 1'b0;
  logic         reset, enable, busy, ack, en30;
  logic [N-1:0] alive;
  logic [N-1:0] alive30;
  logic         fire_req, no_target, req30, nt30;
  logic [3:0]   fire_col, col30;
  logic [1:0]   fire_row, row30;
  logic [7:0]   shots, shots30;

  int n_checks = 0;
  int n_errors = 0;

  int m_rr, m_shots;
  int exp_lat, exp_col, exp_row;

  always #5 clk = ~clk;

  enemy_fire_scheduler #(
    .COLS(COLS), .ROWS(ROWS), .PERIOD_BASE(BASE), .PERIOD_STEP(STEP), .PERIOD_MIN(PMIN)
  ) u_dut (
    .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_alive(alive),
    .i_bullet_busy(busy), .i_fire_ack(ack),
    .o_fire_req(fire_req), .o_fire_col(fire_col), .o_fire_row(fire_row),
    .o_no_target(no_target), .o_shots_fired(shots)
  );

  enemy_fire_scheduler #(
    .COLS(COLS), .ROWS(ROWS), .PERIOD_BASE(30), .PERIOD_STEP(STEP), .PERIOD_MIN(PMIN)
  ) u_dut30 (
    .i_clk(clk), .i_reset(reset), .i_enable(en30), .i_alive(alive30),
    .i_bullet_busy(1'b0), .i_fire_ack(1'b0),
    .o_fire_req(req30), .o_fire_col(col30), .o_fire_row(row30),
    .o_no_target(nt30), .o_shots_fired(shots30)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference cooldown: BASE minus STEP per dead enemy, floored at PMIN
  function automatic int unsigned m_reload(input logic [N-1:0] a, input int unsigned base);
    int unsigned dead = N - $countones(a);
    int unsigned cut  = dead * STEP;
    if (cut > base) return PMIN;
    return ((base - cut) < PMIN) ? PMIN : (base - cut);
  endfunction

  // Reference target: first column from rr with a living enemy, largest row index in it
  task automatic m_target(input logic [N-1:0] a, input int rr,
                          output bit found, output int col, output int row, output int skip);
    found = 0; col = 0; row = 0; skip = 0;
    for (int k = 0; k < COLS && !found; k++) begin
      int c = (rr + k) % COLS;
      for (int r = 0; r < ROWS; r++) begin
        if (a[r*COLS + c]) begin
          found = 1; col = c; row = r; skip = k;
        end
      end
    end
  endtask

  task automatic predict();
    bit f;
    int c, r, k;
    m_target(alive, m_rr, f, c, r, k);
    exp_col = c;
    exp_row = r;
    exp_lat = int'(m_reload(alive, BASE)) + k + 3;
  endtask

  task automatic expect_shot(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!fire_req && n < exp_lat + 5);
    check({tag, "_lat"}, n, exp_lat);
    check({tag, "_col"}, fire_col, exp_col);
    check({tag, "_row"}, fire_row, exp_row);
  endtask

  task automatic ack_shot(input logic [N-1:0] next_alive, input int hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_req", fire_req, 1);
    end
    ack   = 1'b1;
    alive = next_alive;
    tick();
    ack     = 1'b0;
    m_shots = (m_shots + 1) % 256;
    m_rr    = (exp_col + 1) % COLS;
    check("ack_req", fire_req, 0);
    check("ack_shots", shots, m_shots);
    predict();
    exp_lat = exp_lat - 1;
  endtask

  task automatic wait_nt(input bit sel, input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (((sel ? nt30 : no_target) == 1'b0) && n < budget);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, fire_req, 0);
    check({tag, "_col"}, fire_col, 0);
    check({tag, "_row"}, fire_row, 0);
    check({tag, "_nt"}, no_target, 0);
    check({tag, "_shots"}, shots, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, seen;
    logic [N-1:0] a;
    bit f;
    int c, r, k;

    reset = 1'b1; enable = 1'b0; busy = 1'b0; ack = 1'b0; en30 = 1'b0;
    alive = '1; alive30 = '0;
    m_rr = 0; m_shots = 0;
    repeat (3) tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    tick();

    // All-dead grid with BASE=30: cooldown clamps to PMIN
    en30 = 1'b1;
    wait_nt(1'b1, 100, n);
    check("nt30_first", n, m_reload('0, 30) + 10);
    check("nt30_req", req30, 0);
    tick();
    check("nt30_width", nt30, 0);
    wait_nt(1'b1, 100, n);
    check("nt30_period", n + 1, m_reload('0, 30) + 9);
    en30 = 1'b0;

    // First shots from full grid, then sparse corners
    alive = '1;
    predict();
    enable = 1'b1;
    expect_shot("s0");
    ack_shot('1, 0);
    expect_shot("s1");
    ack_shot(24'h000081, 0);
    expect_shot("s2");
    ack_shot(24'h000081, 1);
    expect_shot("s3");

    // Empty grid: full scan, no_target pulse, reload with all dead
    ack = 1'b1; alive = '0;
    tick();
    ack = 1'b0;
    m_shots = m_shots + 1;
    m_rr = (exp_col + 1) % COLS;
    check("nt_shots", shots, m_shots);
    wait_nt(1'b0, 200, n);
    check("nt_first", n + 1, m_reload('0, BASE) + 10);
    check("nt_req", fire_req, 0);
    wait_nt(1'b0, 200, n);
    check("nt_period", n, m_reload('0, BASE) + 9);
    enable = 1'b0;
    tick();
    alive = '1;
    predict();
    enable = 1'b1;
    expect_shot("s4");

    // Bullet in flight blocks issue; release fires two cycles later
    ack = 1'b1; busy = 1'b1;
    tick();
    ack = 1'b0;
    m_shots = m_shots + 1;
    m_rr = (exp_col + 1) % COLS;
    check("busy_shots", shots, m_shots);
    seen = 0;
    repeat (601) begin
      tick();
      if (fire_req) seen++;
    end
    check("busy_hold", seen, 0);
    busy = 1'b0;
    m_target(alive, m_rr, f, c, r, k);
    exp_col = c; exp_row = r; exp_lat = k + 2;
    expect_shot("busy_rel");

    // Latched target survives alive churn; enable beats a coincident ack
    for (int i = 0; i < 50; i++) begin
      alive = N'($urandom);
      tick();
      check("stab_req", fire_req, 1);
      check("stab_col", fire_col, exp_col);
      check("stab_row", fire_row, exp_row);
    end
    enable = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0;
    check("dis_req", fire_req, 0);
    check("dis_shots", shots, m_shots);
    repeat (3) tick();
    check("dis_idle_req", fire_req, 0);

    // Reset in the middle of a multi-column scan
    c = (m_rr + 4) % COLS;
    alive = '0;
    alive[COLS + c] = 1'b1;
    enable = 1'b1;
    repeat (m_reload(alive, BASE) + 4) tick();
    check("scan_req", fire_req, 0);
    reset = 1'b1;
    tick();
    check_reset_outputs("rst_scan");
    alive = '1;
    m_rr = 0; m_shots = 0;
    predict();
    reset = 1'b0;
    expect_shot("post_rst");
    ack_shot('1, 0);
    expect_shot("pre_rst_issue");
    reset = 1'b1;
    tick();
    check_reset_outputs("rst_issue");
    m_rr = 0; m_shots = 0;
    predict();
    reset = 1'b0;

    // 256 accepted shots with random masks and ack delays: counter wraps
    for (int i = 0; i < 256; i++) begin
      expect_shot("rnd");
      a = N'($urandom) | N'($urandom);
      if ($urandom_range(0, 3) == 0) a = a & N'($urandom) & N'($urandom);
      if (a == '0) a[$urandom_range(0, N - 1)] = 1'b1;
      ack_shot(a, int'($urandom_range(0, 3)));
    end
    check("wrap_shots", shots, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
